truth_table_sweeper: RTL
========================

Name: truth_table_sweeper

Overview:
- Stimulus-and-capture stage placed directly upstream of a 4-input combinational function under test (inputs a, b, c, d; output f).
- On a start request it walks all 16 input combinations in ascending order (a = MSB, d = LSB) and holds each one for a fixed number of clocks.
- It samples f once per vector and assembles a 16-bit truth table.
- It compares the table against an expected value and reports done/pass.

Parameters:
- DWELL, 20, clock cycles each vector is held on a..d; legal range 1..255.
- EXPECTED, 16'h0000, golden truth table; bit i = expected f for {a,b,c,d} = i.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  sweep request, sampled on clk; ignored while busy
- f  input  1  output of the function under test
- a  output  1  stimulus bit 3 (MSB of vector index)
- b  output  1  stimulus bit 2
- c  output  1  stimulus bit 1
- d  output  1  stimulus bit 0 (LSB)
- vec_idx  output  4  index of the vector currently driven
- busy  output  1  high while the sweep is in progress
- done  output  1  one-cycle pulse when the sweep completes
- table_out  output  16  captured truth table; bit i = sampled f for vector i
- table_valid  output  1  high from done until the next accepted start
- pass  output  1  table_out == EXPECTED; meaningful only while table_valid = 1, otherwise 0

Behaviour:
- Reset (asynchronous, rst_n = 0): state IDLE. All outputs are 0: a, b, c, d, vec_idx, busy, done, table_out, table_valid, pass. The dwell counter is 0.
- Clock and reset: single clock, asynchronous active-low reset.
- Stimulus mapping: {a,b,c,d} = vec_idx at all times.
- FSM states: IDLE, RUN, FINISH.
- IDLE:
  - On a clk edge with start = 1: go to RUN.
  - vec_idx <= 0, dwell counter <= 0, busy <= 1.
  - table_out <= 0, table_valid <= 0, pass <= 0.
- RUN:
  - Each cycle, dwell counter increments.
  - When dwell counter == DWELL-1 (the last cycle of the vector), sample f into table_out[vec_idx] on that edge.
  - On that same edge, if vec_idx != 15: vec_idx increments and dwell counter resets to 0.
  - If vec_idx == 15: go to FINISH; vec_idx holds at 15.
  - Each vector is therefore driven for exactly DWELL cycles.
  - f is sampled DWELL-1 cycles after the vector change, which gives settling time. With DWELL = 1, f is sampled in the same cycle the vector is driven.
- FINISH (one cycle):
  - done = 1, busy <= 0, table_valid <= 1.
  - pass <= (table_out == EXPECTED), evaluated on the completed table.
  - vec_idx, a..d <= 0.
  - Return to IDLE.
- Timing: start accepted at edge k. busy rises at k+1, done is high during cycle k+1+16*DWELL, and busy is low from the cycle after done.
- start while busy or in FINISH: ignored; no restart, no table clear.
- start held high continuously: a new sweep begins on the first IDLE cycle after FINISH. table_valid then drops for the new sweep.
- table_out bits not yet sampled read 0 during a sweep.
- Reset asserted mid-sweep: immediate return to reset values; a partial table is discarded.
- The dwell counter is 8 bits wide; its compare is done on DWELL-1 with no overflow.

Test Plan:
- Reset check: assert rst_n = 0 mid-sweep (vec_idx = 7) -> all outputs 0 immediately; after release, IDLE with busy = 0.
- Parity: DWELL = 4, EXPECTED = 16'h6996, f = a^b^c^d -> done pulse 65 cycles after the start edge; table_out = 16'h6996, pass = 1, table_valid = 1.
- AND4 mismatch: DWELL = 4, EXPECTED = 16'h6996, f = a&b&c&d -> table_out = 16'h8000, pass = 0.
- Dwell timing: DWELL = 20 -> each a..d value held exactly 20 cycles; vec_idx sequence 0..15; f sampled on the 20th cycle of each vector.
- Start while busy: pulse start at vec_idx = 5 -> no restart; sweep completes normally with one done pulse.
- DWELL = 1, f = a -> table_out = 16'hFF00; done 17 cycles after start; back-to-back start clears table_valid on the next accepted start.

Source files
------------

// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper: drives all 16 combinations of a 4-input function,
// holds each for DWELL clocks, captures f on the last cycle of each vector
// and compares the resulting 16-bit table against EXPECTED.
module truth_table_sweeper #(
  parameter int          DWELL    = 20,
  parameter logic [15:0] EXPECTED = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        f,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic [3:0]  vec_idx,
  output logic        busy,
  output logic        done,
  output logic [15:0] table_out,
  output logic        table_valid,
  output logic        pass
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  // Compare value for the last cycle of a vector; DWELL is at most 255 so
  // this always fits the 8-bit dwell counter.
  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

  state_t     state;
  state_t     state_next;
  logic [7:0] dwell_cnt;
  logic       last_cycle;
  logic       last_vector;

  assign last_cycle  = (dwell_cnt == DWELL_LAST);
  assign last_vector = (vec_idx == 4'd15);

  // Stimulus bits are the vector index itself, a being the MSB.
  assign {a, b, c, d} = vec_idx;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode; done is a one-cycle pulse while in FINISH.
  always_comb begin
    state_next = state;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (last_cycle && last_vector) begin
          state_next = FINISH;
        end
      end
      FINISH: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: vector stepping, dwell counting, capture and result flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_idx     <= 4'd0;
      dwell_cnt   <= 8'd0;
      busy        <= 1'b0;
      table_out   <= 16'd0;
      table_valid <= 1'b0;
      pass        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            vec_idx     <= 4'd0;
            dwell_cnt   <= 8'd0;
            busy        <= 1'b1;
            table_out   <= 16'd0;
            table_valid <= 1'b0;
            pass        <= 1'b0;
          end
        end
        RUN: begin
          if (last_cycle) begin
            table_out[vec_idx] <= f;
            if (!last_vector) begin
              vec_idx   <= vec_idx + 4'd1;
              dwell_cnt <= 8'd0;
            end
          end else begin
            dwell_cnt <= dwell_cnt + 8'd1;
          end
        end
        FINISH: begin
          busy        <= 1'b0;
          table_valid <= 1'b1;
          pass        <= (table_out == EXPECTED);
          vec_idx     <= 4'd0;
          dwell_cnt   <= 8'd0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
